// File: rtl/mdu_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// The pipeline drives the operands and opcode; the unit returns busy, read data and div_zero.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [3:0]       op;
  logic             req;
  logic             busy_o;
  logic [WIDTH-1:0] out;
  logic             div_zero;

  modport master (
    output rs, rt, op, req,
    input  busy_o, out, div_zero
  );

  modport slave (
    input  rs, rt, op, req,
    output busy_o, out, div_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO: fixed-latency multiply with
// multiply-accumulate, and a radix-2 restoring divider.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAXC = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_END = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_negq;
  logic               r_negr;
  logic               r_dz;

  logic w_issue;
  logic w_is_mul;
  logic w_is_div;
  logic w_sgn_mul;
  logic w_acc;
  logic w_sub;
  logic w_sgn_div;
  logic w_rt_zero;
  logic w_start_mul;
  logic w_start_div;
  logic w_dz;
  logic w_mul_done;
  logic w_div_done;

  logic [2*WIDTH-1:0] w_a;
  logic [2*WIDTH-1:0] w_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_mres;
  logic [WIDTH-1:0]   w_abs_rs;
  logic [WIDTH-1:0]   w_abs_rt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;

  assign w_issue   = (r_state == S_IDLE) & ~bus.req;
  assign w_is_mul  = bus.op inside {4'd1, 4'd2, 4'd9,
                                    4'd10, 4'd11, 4'd12};
  assign w_is_div  = bus.op inside {4'd3, 4'd4};
  assign w_sgn_mul = bus.op inside {4'd1, 4'd9, 4'd11};
  assign w_acc     = bus.op inside {4'd9, 4'd10,
                                    4'd11, 4'd12};
  assign w_sub     = bus.op inside {4'd11, 4'd12};
  assign w_sgn_div = bus.op == 4'd3;
  assign w_rt_zero = bus.rt == '0;

  assign w_start_mul = w_issue & w_is_mul;
  assign w_start_div = w_issue & w_is_div & ~w_rt_zero;
  assign w_dz        = w_issue & w_is_div & w_rt_zero;
  assign w_mul_done  = (r_state == S_MUL) & (r_cnt == MUL_END);
  assign w_div_done  = (r_state == S_DIV) & (r_cnt == DIV_END);

  // Extending to 2*WIDTH makes one multiplier serve both signednesses.
  assign w_a = w_sgn_mul ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs}
                         : {{WIDTH{1'b0}}, bus.rs};
  assign w_b = w_sgn_mul ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt}
                         : {{WIDTH{1'b0}}, bus.rt};
  assign w_prod = w_a * w_b;
  assign w_hilo = {r_hi, r_lo};
  assign w_mres = !w_acc ? w_prod
                : w_sub  ? w_hilo - w_prod
                         : w_hilo + w_prod;

  assign w_abs_rs = (w_sgn_div & bus.rs[WIDTH-1]) ? -bus.rs
                                                  : bus.rs;
  assign w_abs_rt = (w_sgn_div & bus.rt[WIDTH-1]) ? -bus.rt
                                                  : bus.rt;

  // r_quo shifts dividend bits out the top and quotient bits in.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_start_mul: w_state_nx = S_MUL;
          w_start_div: w_state_nx = S_DIV;
          default:     w_state_nx = S_IDLE;
        endcase
      end
      S_MUL:   if (w_mul_done) w_state_nx = S_IDLE;
      S_DIV:   if (w_div_done) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_dz <= w_dz;
      if (r_state == S_IDLE) begin
        if (w_issue && bus.op == 4'd7) r_hi <= bus.rs;
        if (w_issue && bus.op == 4'd8) r_lo <= bus.rs;
        if (w_start_mul) begin
          r_acc <= w_mres;
          r_cnt <= '0;
        end
        if (w_start_div) begin
          r_quo  <= w_abs_rs;
          r_dvs  <= w_abs_rt;
          r_rem  <= '0;
          r_negq <= w_sgn_div & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
          r_negr <= w_sgn_div & bus.rs[WIDTH-1];
          r_cnt  <= '0;
        end
      end else if (r_state == S_MUL) begin
        if (w_mul_done) begin
          {r_hi, r_lo} <= r_acc;
          r_cnt        <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (r_state == S_DIV) begin
        if (w_div_done) begin
          r_lo  <= r_negq ? -r_quo : r_quo;
          r_hi  <= r_negr ? -r_rem : r_rem;
          r_cnt <= '0;
        end else begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0]
                        : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.busy_o   = (r_state != S_IDLE)
                      | (~bus.req & (w_is_mul | w_is_div));
  assign bus.out      = (bus.op == 4'd5) ? r_hi
                      : (bus.op == 4'd6) ? r_lo
                                         : '0;
  assign bus.div_zero = r_dz;
endmodule
